// File: rtl/lc2k_program_loader.sv
// lc2k_program_loader
//
// Fills LC2K instruction memory from a framed byte stream and then releases
// the CPU. The frame layout is:
//   LEN_HI, LEN_LO      16-bit word count N, big-endian
//   N x 4 payload bytes  big-endian words (first byte -> bits [31:24])
//   checksum byte       XOR of all payload bytes (length bytes excluded)
// Each completed word is written with a one-cycle mem_wr_en strobe.
// cpu_run is raised once the checksum matches. load_err is raised if the
// length is too large or the checksum does not match. Both states wait for
// a restart pulse.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_ready   8-bit valid/ready byte stream
//   restart        one-cycle pulse, honoured only in DONE or ERR
//   mem_wr_en/mem_wr_addr/mem_wr_data   instruction-memory write port
//   cpu_run        high only in DONE (CPU is held in halt while low)
//   load_err       high only in ERR
//   words_loaded   number of words written in the current load

module lc2k_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_SUM    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // One bit wider than the length field so that DEPTH = 65536 still compares correctly.
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);

  logic [2:0]  state;
  logic [7:0]  len_hi;
  logic [15:0] word_count;
  logic [23:0] word_reg;
  logic [1:0]  byte_idx;
  logic [7:0]  acc;

  logic        xfer;
  logic [15:0] rx_len;
  logic        last_word;

  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_SUM);
  assign cpu_run  = (state == S_DONE);
  assign load_err = (state == S_ERR);

  assign xfer   = in_valid && in_ready;
  assign rx_len = {len_hi, in_data};

  // Strobes are at least four cycles apart. So when the 4th byte of a word
  // arrives, words_loaded already counts every earlier word.
  assign last_word = ((words_loaded + 16'd1) == word_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LEN_HI;
      len_hi       <= 8'd0;
      word_count   <= 16'd0;
      word_reg     <= 24'd0;
      byte_idx     <= 2'd0;
      acc          <= 8'd0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      mem_wr_en <= 1'b0;

      // The address advances after each strobe, but not after the final word.
      // This keeps the address from wrapping when N == DEPTH == 2**ADDR_W.
      if (mem_wr_en && (words_loaded != word_count)) begin
        mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
      end

      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            word_count <= rx_len;
            if (rx_len == 16'd0) begin
              state <= S_SUM;
            end else if ({1'b0, rx_len} > DEPTH_LIMIT) begin
              state <= S_ERR;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            word_reg <= {word_reg[15:0], in_data};
            acc      <= acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_wr_en    <= 1'b1;
              mem_wr_data  <= {word_reg, in_data};
              words_loaded <= words_loaded + 16'd1;
              if (last_word) begin
                state <= S_SUM;
              end
            end
          end
        end

        S_SUM: begin
          if (xfer) begin
            state <= (in_data == acc) ? S_DONE : S_ERR;
          end
        end

        S_DONE, S_ERR: begin
          if (restart) begin
            state        <= S_LEN_HI;
            words_loaded <= 16'd0;
            acc          <= 8'd0;
            byte_idx     <= 2'd0;
            word_reg     <= 24'd0;
            mem_wr_addr  <= '0;
          end
        end

        default: begin
          state <= S_LEN_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc2k_program_loader.sv
// Testbench for lc2k_program_loader.
//
// The stimulus process sends framed byte streams. It pushes the write
// (address, data, words_loaded) that each frame must produce into a queue.
// A separate monitor checks every mem_wr_en strobe against that queue on
// the falling edge. Status outputs are checked directly after each frame.

module tb_lc2k_program_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_run;
  logic        load_err;
  logic [15:0] words_loaded;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [15:0] wl;
  } wr_t;

  wr_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] frame_good [11] = '{8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07,
                                  8'h01, 8'h80, 8'h00, 8'h00, 8'h07};

  lc2k_program_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Send one byte after 'gap' idle cycles, waiting (bounded) for in_ready.
  // Returns at posedge+1, just after the byte has transferred.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic sendGoodFrame(input bit random_gaps, input bit poke_restart);
    exp_q.push_back('{addr: 8'd0, data: 32'h00810007, wl: 16'd1});
    exp_q.push_back('{addr: 8'd1, data: 32'h01800000, wl: 16'd2});
    for (int i = 0; i < 11; i++) begin
      applyStimulus(frame_good[i], random_gaps ? int'($urandom_range(0, 3)) : 0);
      if (poke_restart && i == 4) begin
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
      end
    end
  endtask

  task automatic pulseRestart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic checkDone(input string tag, input logic [15:0] wl);
    @(negedge clk);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
    checkOutput({tag, "_load_err"}, 32'(load_err), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
    checkOutput({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "_load_err"}, 32'(load_err), 32'd0);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Write-port monitor: every strobe must match the head of the queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                   mem_wr_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
          checkOutput("wr_data", mem_wr_data, e.data);
          checkOutput("wr_words_loaded", 32'(words_loaded), 32'(e.wl));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: a good two-word frame.
    sendGoodFrame(1'b0, 1'b0);
    checkDone("good", 16'd2);
    // A byte offered in DONE must not be accepted and must not disturb anything.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("done_hold_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("done_hold_words", 32'(words_loaded), 32'd2);
    pulseRestart();
    checkIdle("restart1");

    // Scenario 2: bad checksum.
    exp_q.push_back('{addr: 8'd0, data: 32'h00810007, wl: 16'd1});
    exp_q.push_back('{addr: 8'd1, data: 32'h01800000, wl: 16'd2});
    for (int i = 0; i < 10; i++) applyStimulus(frame_good[i], 0);
    applyStimulus(8'h08, 0);
    @(negedge clk);
    checkOutput("badsum_load_err", 32'(load_err), 32'd1);
    checkOutput("badsum_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("badsum_in_ready", 32'(in_ready), 32'd0);
    checkOutput("badsum_words_loaded", 32'(words_loaded), 32'd2);
    checkOutput("badsum_writes_pending", 32'(exp_q.size()), 32'd0);
    pulseRestart();
    checkIdle("restart2");

    // Scenario 3: empty program.
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkDone("empty", 16'd0);
    pulseRestart();
    checkIdle("restart3");

    // Scenario 4: length 257 exceeds DEPTH.
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    @(negedge clk);
    checkOutput("toolong_load_err", 32'(load_err), 32'd1);
    checkOutput("toolong_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("toolong_hold_err", 32'(load_err), 32'd1);
    checkOutput("toolong_words_loaded", 32'(words_loaded), 32'd0);
    pulseRestart();
    checkIdle("restart4");

    // Scenario 5: random gaps, and a restart during S_DATA that must be ignored.
    sendGoodFrame(1'b1, 1'b1);
    checkDone("gappy", 16'd2);
    pulseRestart();
    checkIdle("restart5");

    // Scenario 6: reset after 6 bytes, then reload the whole frame.
    for (int i = 0; i < 6; i++) applyStimulus(frame_good[i], 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_mem_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("abort_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    checkOutput("abort_mem_wr_data", mem_wr_data, 32'd0);
    checkOutput("abort_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("abort_words_loaded", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sendGoodFrame(1'b0, 1'b0);
    checkDone("reload", 16'd2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
